// File: rtl/vga_timing_gen_if.sv
// Raster bus between the VGA timing generator and its consumers.
// The generator takes the master modport; painters and the VGA connector take the slave modport.
interface vga_timing_gen_if;
    logic        pixelEn;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        hSync;
    logic        vSync;
    logic        displayEn;
    logic        startOfFrame;
    logic [7:0]  frameCount;

    modport master (
        input  pixelEn,
        output pixelX,
        output pixelY,
        output hSync,
        output vSync,
        output displayEn,
        output startOfFrame,
        output frameCount
    );

    modport slave (
        output pixelEn,
        input  pixelX,
        input  pixelY,
        input  hSync,
        input  vSync,
        input  displayEn,
        input  startOfFrame,
        input  frameCount
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing generator: pixel coordinates, active-low syncs,
// display enable, start-of-frame pulse and a free-running frame counter.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic              clk,
    input  logic              resetN,
    vga_timing_gen_if.master  vga
);

    localparam logic [10:0] H_LAST       = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] V_LAST       = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] r_pixelX;
    logic [10:0] r_pixelY;
    logic        r_hSync;
    logic        r_vSync;
    logic        r_displayEn;
    logic        r_startOfFrame;
    logic [7:0]  r_frameCount;

    logic        w_lastX;
    logic        w_lastY;
    logic        w_frameWrap;
    logic [10:0] w_nextX;
    logic [10:0] w_nextY;
    logic        w_nextHSync;
    logic        w_nextVSync;
    logic        w_nextDisplayEn;

    // Decode every output from the coordinate the raster is about to move to,
    // so the registered flags always match the registered coordinates.
    always_comb begin
        w_lastX         = (r_pixelX == H_LAST);
        w_lastY         = (r_pixelY == V_LAST);
        w_frameWrap     = w_lastX && w_lastY;
        w_nextX         = w_lastX ? 11'd0 : r_pixelX + 11'd1;
        w_nextY         = r_pixelY;
        if (w_lastX) begin
            w_nextY = w_lastY ? 11'd0 : r_pixelY + 11'd1;
        end
        w_nextHSync     = !((w_nextX >= H_SYNC_START) && (w_nextX < H_SYNC_END));
        w_nextVSync     = !((w_nextY >= V_SYNC_START) && (w_nextY < V_SYNC_END));
        w_nextDisplayEn = (w_nextX < H_VIS_END) && (w_nextY < V_VIS_END);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pixelX       <= 11'd0;
            r_pixelY       <= 11'd0;
            r_hSync        <= 1'b1;
            r_vSync        <= 1'b1;
            r_displayEn    <= 1'b0;
            r_startOfFrame <= 1'b0;
            r_frameCount   <= 8'd0;
        end else if (vga.pixelEn) begin
            r_pixelX       <= w_nextX;
            r_pixelY       <= w_nextY;
            r_hSync        <= w_nextHSync;
            r_vSync        <= w_nextVSync;
            r_displayEn    <= w_nextDisplayEn;
            r_startOfFrame <= w_frameWrap;
            if (w_frameWrap) begin
                r_frameCount <= r_frameCount + 8'd1;
            end
        end else begin
            r_startOfFrame <= 1'b0;
        end
    end

    assign vga.pixelX       = r_pixelX;
    assign vga.pixelY       = r_pixelY;
    assign vga.hSync        = r_hSync;
    assign vga.vSync        = r_vSync;
    assign vga.displayEn    = r_displayEn;
    assign vga.startOfFrame = r_startOfFrame;
    assign vga.frameCount   = r_frameCount;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full 640x480 instance for line-level timing
// and a scaled-down raster (8x9) so whole frames and the frame counter wrap fit in a short run.
module tb_vga_timing_gen;

    logic clk;
    logic resetN;

    int compareCount;
    int mismatchCount;

    vga_timing_gen_if fullIf ();
    vga_timing_gen_if smallIf ();

    vga_timing_gen dutFull (
        .clk    (clk),
        .resetN (resetN),
        .vga    (fullIf)
    );

    vga_timing_gen #(
        .H_VISIBLE (4),
        .H_FRONT   (1),
        .H_SYNC    (2),
        .H_BACK    (1),
        .V_VISIBLE (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (2)
    ) dutSmall (
        .clk    (clk),
        .resetN (resetN),
        .vga    (smallIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock on the full-size instance with the given pixelEn, sampled 1ns after the edge.
    task automatic applyStimulus(input logic en);
        fullIf.pixelEn = en;
        @(posedge clk);
        #1;
    endtask

    task automatic checkFullReset(input string tag);
        checkOutput(tag, 64'({fullIf.pixelX, fullIf.pixelY, fullIf.frameCount, fullIf.hSync,
                              fullIf.vSync, fullIf.displayEn, fullIf.startOfFrame}),
                         64'({11'd0, 11'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
    endtask

    initial begin
        logic        hExp;
        logic        deExp;
        logic [10:0] ex;
        logic [10:0] ey;
        logic [7:0]  ef;
        logic        sofExp;
        logic        hsExp;
        logic        vsExp;
        logic        dsExp;
        int          lastSof;

        compareCount   = 0;
        mismatchCount  = 0;
        resetN         = 1'b0;
        fullIf.pixelEn = 1'b0;
        smallIf.pixelEn = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkFullReset("reset_initial");
        resetN = 1'b1;

        repeat (20) applyStimulus(1'b1);
        checkOutput("count_before_reset", 64'(fullIf.pixelX), 64'(20));

        // Drop reset between edges and look before the next edge arrives.
        #2;
        resetN = 1'b0;
        #1;
        checkFullReset("reset_async");
        @(posedge clk);
        #1;
        resetN = 1'b1;

        applyStimulus(1'b0);
        checkOutput("idle_after_reset", 64'({fullIf.pixelX, fullIf.displayEn}), 64'({11'd0, 1'b0}));

        applyStimulus(1'b1);
        checkOutput("first_tick", 64'({fullIf.pixelX, fullIf.pixelY, fullIf.displayEn, fullIf.hSync,
                                       fullIf.startOfFrame}),
                                  64'({11'd1, 11'd0, 1'b1, 1'b1, 1'b0}));

        for (int i = 2; i < 800; i++) begin
            applyStimulus(1'b1);
            hExp  = !((i >= 656) && (i <= 751));
            deExp = (i < 640);
            checkOutput($sformatf("line0_x%0d", i),
                        64'({fullIf.pixelX, fullIf.hSync, fullIf.displayEn}),
                        64'({11'(i), hExp, deExp}));
        end

        applyStimulus(1'b1);
        checkOutput("line_wrap_1", 64'({fullIf.pixelX, fullIf.pixelY, fullIf.displayEn, fullIf.hSync}),
                                   64'({11'd0, 11'd1, 1'b1, 1'b1}));

        repeat (7999) applyStimulus(1'b1);
        checkOutput("pre_wrap_799_10", 64'({fullIf.pixelX, fullIf.pixelY, fullIf.displayEn, fullIf.hSync}),
                                       64'({11'd799, 11'd10, 1'b0, 1'b1}));
        applyStimulus(1'b1);
        checkOutput("line_wrap_11", 64'({fullIf.pixelX, fullIf.pixelY, fullIf.displayEn, fullIf.vSync}),
                                    64'({11'd0, 11'd11, 1'b1, 1'b1}));

        repeat (100) applyStimulus(1'b1);
        checkOutput("hold_start", 64'({fullIf.pixelX, fullIf.pixelY}), 64'({11'd100, 11'd11}));
        applyStimulus(1'b1);
        checkOutput("hold_en1", 64'({fullIf.pixelX, fullIf.pixelY, fullIf.startOfFrame}),
                                64'({11'd101, 11'd11, 1'b0}));
        applyStimulus(1'b0);
        checkOutput("hold_en0_a", 64'({fullIf.pixelX, fullIf.pixelY, fullIf.startOfFrame}),
                                  64'({11'd101, 11'd11, 1'b0}));
        applyStimulus(1'b0);
        checkOutput("hold_en0_b", 64'({fullIf.pixelX, fullIf.pixelY, fullIf.startOfFrame}),
                                  64'({11'd101, 11'd11, 1'b0}));
        applyStimulus(1'b1);
        checkOutput("hold_en1_again", 64'({fullIf.pixelX, fullIf.pixelY, fullIf.startOfFrame, fullIf.frameCount}),
                                      64'({11'd102, 11'd11, 1'b0, 8'd0}));
        fullIf.pixelEn = 1'b0;

        // Scaled raster: 8 pixels per line, 9 lines per frame, 72 clocks per frame.
        checkOutput("small_reset", 64'({smallIf.pixelX, smallIf.pixelY, smallIf.frameCount,
                                        smallIf.startOfFrame, smallIf.displayEn}),
                                   64'({11'd0, 11'd0, 8'd0, 1'b0, 1'b0}));
        smallIf.pixelEn = 1'b1;
        lastSof = 0;
        for (int n = 1; n <= 256 * 72 + 2; n++) begin
            @(posedge clk);
            #1;
            ex     = 11'(n % 8);
            ey     = 11'((n / 8) % 9);
            ef     = 8'((n / 72) % 256);
            sofExp = ((n % 72) == 0);
            hsExp  = !((ex == 11'd5) || (ex == 11'd6));
            vsExp  = !((ey == 11'd5) || (ey == 11'd6));
            dsExp  = (ex < 11'd4) && (ey < 11'd4);
            checkOutput($sformatf("small_n%0d", n),
                        64'({smallIf.pixelX, smallIf.pixelY, smallIf.frameCount, smallIf.startOfFrame,
                             smallIf.hSync, smallIf.vSync, smallIf.displayEn}),
                        64'({ex, ey, ef, sofExp, hsExp, vsExp, dsExp}));
            if (n == 255 * 72 + 71) begin
                checkOutput("pre_frame_wrap", 64'({smallIf.pixelX, smallIf.pixelY, smallIf.frameCount}),
                                              64'({11'd7, 11'd8, 8'd255}));
            end
            if (n == 256 * 72) begin
                checkOutput("frame_wrap", 64'({smallIf.pixelX, smallIf.pixelY, smallIf.frameCount,
                                               smallIf.startOfFrame}),
                                          64'({11'd0, 11'd0, 8'd0, 1'b1}));
            end
            if (n == 256 * 72 + 1) begin
                checkOutput("sof_one_clk", 64'(smallIf.startOfFrame), 64'(0));
            end
            if (smallIf.startOfFrame) begin
                if (lastSof != 0) begin
                    checkOutput("frame_period", 64'(n - lastSof), 64'(72));
                end
                lastSof = n;
            end
        end
        smallIf.pixelEn = 1'b0;
        checkOutput("sof_seen", 64'(lastSof), 64'(256 * 72));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the 640x480 VGA path.
- Produces the pixelX/pixelY coordinates consumed by the background painter and all object drawers.
- Produces the hSync/vSync pulses driven to the VGA connector, plus a display-enable flag, a start-of-frame pulse and a frame counter for game-logic timing.
- Runs on the system clock; advances one pixel per pixelEn tick.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- pixelEn  in  1  pixel-rate tick; counters advance only on cycles where it is high
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1
- pixelY  out  11  current vertical count, 0..V_TOTAL-1
- hSync  out  1  horizontal sync, active low
- vSync  out  1  vertical sync, active low
- displayEn  out  1  high while pixelX<H_VISIBLE and pixelY<V_VISIBLE
- startOfFrame  out  1  one-clk pulse when the raster wraps to (0,0)
- frameCount  out  8  free-running frame counter

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- All outputs are flops. On each advancing edge they are decoded from the next counter value, so sync, displayEn and startOfFrame are always coherent with the pixelX/pixelY presented in the same cycle.
- Reset (async, resetN low), held until release:
  - pixelX=0, pixelY=0, frameCount=0
  - hSync=1, vSync=1, displayEn=0, startOfFrame=0
- pixelEn low: all outputs hold their values, except startOfFrame, which is 0.
- On pixelEn high, horizontal count:
  - pixelX<H_TOTAL-1: pixelX <= pixelX+1.
  - pixelX==H_TOTAL-1: pixelX <= 0.
- Vertical count changes only on the horizontal wrap:
  - pixelY<V_TOTAL-1: pixelY <= pixelY+1.
  - pixelY==V_TOTAL-1: pixelY <= 0, frameCount <= frameCount+1 (8-bit wrap, 255 -> 0), startOfFrame <= 1 for exactly one clk.
- hSync is 0 iff H_VISIBLE+H_FRONT <= pixelX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
- vSync is 0 iff V_VISIBLE+V_FRONT <= pixelY < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 490..491. The whole line is affected, independent of pixelX.
- displayEn after reset: stays 0 until the first pixelEn. The first advance moves the raster to (1,0) with displayEn=1. Coordinate (0,0) is first shown as visible after the first full-frame wrap.
- The first frame after reset does not raise startOfFrame.
- Reset mid-frame: immediate return to reset values. No partial pulse completes; startOfFrame drops at once if high.
- pixelEn held high continuously is legal. It gives a clk-rate raster, used by simulation benches.

Test Plan:
- Reset and first tick: assert resetN=0 mid-count. Require all outputs at reset values asynchronously, before the next clk edge. Release reset and apply one pixelEn; require pixelX=1, pixelY=0, displayEn=1, hSync=1.
- Line wrap: run pixelEn continuously from (799,10). Require next (0,11); displayEn transitions 0 -> 1 at the wrap.
- Horizontal sync window: scan line 0. Require hSync=1 at pixelX=655, 0 at 656 and at 751, 1 at 752. Require displayEn=0 for pixelX from 640 through 799.
- Vertical sync window: require vSync=0 for all of lines 490 and 491, and vSync=1 on lines 489 and 492.
- Frame wrap: preload the state by running to (799,524) with frameCount=255. The next tick gives (0,0), frameCount=0, startOfFrame=1 for one clk only. Require startOfFrame=0 on the following cycle.
- Hold with pixelEn: toggle pixelEn 1,0,0,1 starting at (100,50). Require (101,50), held for two cycles, then (102,50). Require startOfFrame=0 throughout.
- Full-frame period: with pixelEn=1 continuously, require the gap between startOfFrame pulses to be exactly 420000 clk cycles (800x525).
